// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and the memory.
//   master : load_store_unit (drives request, write enable, address, enables, data)
//   slave  : memory model    (drives busAck, busRdata)
// Signals:
//   busReq   request, held until busAck
//   busWe    1 = write
//   busAddr  word address (ADDR_W-2 bits)
//   busBe    byte enables
//   busWdata lane-replicated store data
//   busAck   transfer done, busRdata valid in the same cycle
//   busRdata read word
interface load_store_unit_if #(
  parameter int ADDR_W = 16
);
  logic              busReq;
  logic              busWe;
  logic [ADDR_W-3:0] busAddr;
  logic [3:0]        busBe;
  logic [31:0]       busWdata;
  logic              busAck;
  logic [31:0]       busRdata;

  modport master (
    output busReq, busWe, busAddr, busBe, busWdata,
    input  busAck, busRdata
  );

  modport slave (
    input  busReq, busWe, busAddr, busBe, busWdata,
    output busAck, busRdata
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage. Runs one req/ack bus transaction per
// legal load/store, formats store lanes, extends load data and stalls the core
// until the access completes.
// Parameters: ADDR_W  byte-address bits decoded (upper address bits ignored)
//             TIMEOUT bus-wait limit in cycles (only with LSU_BUS_TIMEOUT_EN)
// Optional feature macro: LSU_BUS_TIMEOUT_EN (bus wait timeout with fault).
// Ports: clk, rst (async, active-high)
//        memRead, memWrite, f3, addr, writeData   core request
//        readData (registered), stall (comb), fault (one-cycle pulse)
//        bus                                      load_store_unit_if.master
module load_store_unit #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  f3,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        stall,
  output logic        fault,
  load_store_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, BUS, DONE} stateT;

  stateT       state;
  logic        isLoad;
  logic [2:0]  accF3;
  logic [1:0]  accLane;

  logic        req;
  logic        f3Ok;
  logic        alignOk;
  logic        legal;
  logic [3:0]  stBe;
  logic [31:0] stWdata;
  logic [31:0] laneWord;
  logic [7:0]  ldByte;
  logic [15:0] ldHalf;
  logic [31:0] ldVal;
  logic        unusedAddrBits;

  assign unusedAddrBits = ^addr[31:ADDR_W];
  assign req = memRead | memWrite;

  always_comb begin
    f3Ok = memRead ? (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                   : (f3 inside {3'b000, 3'b001, 3'b010});
    case (f3[1:0])
      2'b01:   alignOk = !addr[0];
      2'b10:   alignOk = (addr[1:0] == 2'b00);
      default: alignOk = 1'b1;
    endcase
    legal = f3Ok && alignOk && !(memRead && memWrite);
  end

  always_comb begin
    case (f3[1:0])
      2'b00: begin
        stBe    = 4'b0001 << addr[1:0];
        stWdata = {4{writeData[7:0]}};
      end
      2'b01: begin
        stBe    = addr[1] ? 4'b1100 : 4'b0011;
        stWdata = {2{writeData[15:0]}};
      end
      default: begin
        stBe    = 4'b1111;
        stWdata = writeData;
      end
    endcase
    if (memRead) stBe = 4'b1111;
  end

  // Load extraction works from the latched lane/funct3, not the live core inputs.
  always_comb begin
    laneWord = bus.busRdata >> {accLane, 3'b000};
    ldByte   = laneWord[7:0];
    ldHalf   = accLane[1] ? bus.busRdata[31:16] : bus.busRdata[15:0];
    case (accF3)
      3'b000:  ldVal = {{24{ldByte[7]}}, ldByte};
      3'b001:  ldVal = {{16{ldHalf[15]}}, ldHalf};
      3'b100:  ldVal = {24'd0, ldByte};
      3'b101:  ldVal = {16'd0, ldHalf};
      default: ldVal = bus.busRdata;
    endcase
  end

  // Stall is combinational so the core freezes in the request cycle itself.
  assign stall = !rst && ((state == BUS) || ((state == IDLE) && req));

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] waitCnt;
  logic          expired;
  assign expired = (waitCnt == CW'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      readData     <= '0;
      fault        <= 1'b0;
      bus.busReq   <= 1'b0;
      bus.busWe    <= 1'b0;
      bus.busAddr  <= '0;
      bus.busBe    <= '0;
      bus.busWdata <= '0;
      isLoad       <= 1'b0;
      accF3        <= '0;
      accLane      <= '0;
`ifdef LSU_BUS_TIMEOUT_EN
      waitCnt      <= '0;
`endif
    end else begin
      fault <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            if (legal) begin
              isLoad       <= memRead;
              accF3        <= f3;
              accLane      <= addr[1:0];
              bus.busWe    <= memWrite;
              bus.busAddr  <= addr[ADDR_W-1:2];
              bus.busBe    <= stBe;
              bus.busWdata <= stWdata;
              bus.busReq   <= 1'b1;
`ifdef LSU_BUS_TIMEOUT_EN
              waitCnt      <= '0;
`endif
              state        <= BUS;
            end else begin
              fault <= 1'b1;
              if (memRead) readData <= '0;
              state <= DONE;
            end
          end
        end
        BUS: begin
          if (bus.busAck) begin
            if (isLoad) readData <= ldVal;
            bus.busReq <= 1'b0;
            state      <= DONE;
          end
`ifdef LSU_BUS_TIMEOUT_EN
          else if (expired) begin
            bus.busReq <= 1'b0;
            fault      <= 1'b1;
            if (isLoad) readData <= '0;
            state      <= DONE;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
`endif
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        memRead, memWrite;
  logic [2:0]  f3;
  logic [31:0] addr, writeData;
  logic [31:0] readData;
  logic        stall, fault;

  load_store_unit_if #(.ADDR_W(16)) busIf ();

  load_store_unit #(.ADDR_W(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .memRead(memRead), .memWrite(memWrite), .f3(f3),
    .addr(addr), .writeData(writeData), .readData(readData), .stall(stall),
    .fault(fault), .bus(busIf.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int stallCnt = 0;

  // expected outputs for the current cycle
  logic        chkEn = 1'b0;
  logic        expStall, expReq, expFault, expWe;
  logic [31:0] mRd;
  logic [13:0] expAddr;
  logic [3:0]  expBe;
  logic [31:0] expWd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model -----------------
  function automatic logic isLegal(logic rd, logic wr, logic [2:0] f, logic [31:0] a);
    int unsigned sz;
    logic f3Ok;
    sz   = 1 << f[1:0];
    f3Ok = rd ? (f == 0 || f == 1 || f == 2 || f == 4 || f == 5) : (f <= 2);
    return (rd != wr) && f3Ok && ((a % sz) == 0);
  endfunction

  function automatic logic [31:0] ldVal(logic [2:0] f, logic [31:0] a, logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * a[1:0])) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    case (f)
      3'd0:    return (b >= 128) ? 32'(int'(b) - 256) : 32'(b);
      3'd1:    return (h >= 32768) ? 32'(int'(h) - 65536) : 32'(h);
      3'd4:    return 32'(b);
      3'd5:    return 32'(h);
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] stBeM(logic rd, logic [2:0] f, logic [31:0] a);
    if (rd) return 4'hF;
    case (f[1:0])
      2'd0:    return 4'(1 << a[1:0]);
      2'd1:    return a[1] ? 4'hC : 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] stWdM(logic [2:0] f, logic [31:0] w);
    case (f[1:0])
      2'd0:    return (w & 32'hFF) * 32'h0101_0101;
      2'd1:    return (w & 32'hFFFF) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  // ---------------- compare process -----------------
  always @(negedge clk) begin
    if (chkEn) begin
      chk("stall", 32'(stall), 32'(expStall));
      chk("busReq", 32'(busIf.busReq), 32'(expReq));
      chk("fault", 32'(fault), 32'(expFault));
      chk("readData", readData, mRd);
      if (expReq) begin
        chk("busWe", 32'(busIf.busWe), 32'(expWe));
        chk("busAddr", 32'(busIf.busAddr), 32'(expAddr));
        chk("busBe", 32'(busIf.busBe), 32'(expBe));
        if (expWe) chk("busWdata", busIf.busWdata, expWd);
      end
      if (stall === 1'b1) stallCnt++;
    end
  end

  // ---------------- stimulus helpers -----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    memRead   = 1'($urandom);
    memWrite  = 1'($urandom);
    f3        = 3'($urandom);
    addr      = $urandom;
    writeData = $urandom;
  endtask

  task automatic nop();
    memRead = 1'b0; memWrite = 1'b0;
    f3 = 3'($urandom); addr = $urandom; writeData = $urandom;
    busIf.busAck = 1'($urandom); busIf.busRdata = $urandom;
    expStall = 1'b0; expReq = 1'b0; expFault = 1'b0;
    step();
  endtask

  task automatic doAccess(input logic rd, input logic wr, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int waits, input logic [31:0] rdata);
    logic legal, expired;
    int   busCycles;
    stallCnt = 0;
    legal = isLegal(rd, wr, f, a);
    expired = 1'b0;
    busCycles = waits + 1;
`ifdef LSU_BUS_TIMEOUT_EN
    if (waits >= TMO) begin
      expired   = 1'b1;
      busCycles = TMO;
    end
`endif
    memRead = rd; memWrite = wr; f3 = f; addr = a; writeData = wd;
    busIf.busAck = 1'($urandom); busIf.busRdata = $urandom;
    expStall = 1'b1; expReq = 1'b0; expFault = 1'b0;
    step();
    if (legal) begin
      expWe = wr; expAddr = a[15:2]; expBe = stBeM(rd, f, a); expWd = stWdM(f, wd);
      for (int k = 0; k < busCycles; k++) begin
        scramble();
        busIf.busAck   = (k == waits);
        busIf.busRdata = (k == waits) ? rdata : $urandom;
        expStall = 1'b1; expReq = 1'b1; expFault = 1'b0;
        step();
      end
      if (rd) mRd = expired ? 32'd0 : ldVal(f, a, rdata);
      expFault = expired;
    end else begin
      if (rd) mRd = 32'd0;
      expFault = 1'b1;
    end
    scramble();
    busIf.busAck = 1'($urandom); busIf.busRdata = $urandom;
    expStall = 1'b0; expReq = 1'b0;
    step();
  endtask

  // ---------------- main sequence -----------------
  initial begin
    rst = 1'b1;
    memRead = 1'b1; memWrite = 1'b0; f3 = 3'd2; addr = 32'd0; writeData = 32'd0;
    busIf.busAck = 1'b0; busIf.busRdata = 32'd0;
    mRd = 32'd0; expWe = 1'b0; expAddr = '0; expBe = '0; expWd = '0;
    expStall = 1'b0; expReq = 1'b0; expFault = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_readData", readData, 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_busReq", 32'(busIf.busReq), 32'd0);
    chk("rst_busWe", 32'(busIf.busWe), 32'd0);
    chk("rst_busAddr", 32'(busIf.busAddr), 32'd0);
    chk("rst_busBe", 32'(busIf.busBe), 32'd0);
    chk("rst_busWdata", busIf.busWdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chkEn = 1'b1;

    // both requests high: illegal, readData already 0
    doAccess(1'b1, 1'b1, 3'd2, 32'h0, 32'h0, 0, 32'h0);
    nop();

    // LB sign extension
    doAccess(1'b1, 1'b0, 3'd0, 32'h0003, 32'h0, 0, 32'h80FF_1234);
    chk("lb_readData", readData, 32'hFFFF_FF80);
    chk("lb_busAddr", 32'(busIf.busAddr), 32'd0);
    chk("lb_stallCycles", 32'(stallCnt), 32'd2);

    // SH upper half, 3 wait cycles
    doAccess(1'b0, 1'b1, 3'd1, 32'h0006, 32'h0000_BEEF, 3, 32'h0);
    chk("sh_busWe", 32'(busIf.busWe), 32'd1);
    chk("sh_busBe", 32'(busIf.busBe), 32'b1100);
    chk("sh_busWdata", busIf.busWdata, 32'hBEEF_BEEF);
    chk("sh_busAddr", 32'(busIf.busAddr), 32'd1);
    chk("sh_stallCycles", 32'(stallCnt), 32'd5);
    chk("sh_readData", readData, 32'hFFFF_FF80);

    // misaligned LW
    doAccess(1'b1, 1'b0, 3'd2, 32'h0002, 32'h0, 0, 32'h0);
    chk("mis_readData", readData, 32'd0);
    chk("mis_stallCycles", 32'(stallCnt), 32'd1);

    // LHU then back-to-back SW
    doAccess(1'b1, 1'b0, 3'd5, 32'h0002, 32'h0, 0, 32'h8001_0000);
    chk("lhu_readData", readData, 32'h0000_8001);
    doAccess(1'b0, 1'b1, 3'd2, 32'h0008, 32'hCAFE_F00D, 1, 32'h0);
    chk("sw_busWdata", busIf.busWdata, 32'hCAFE_F00D);

    // reset during a bus wait, late ack afterwards
    doAccess(1'b1, 1'b0, 3'd2, 32'h0010, 32'h0, 0, 32'h1234_5678);
    memRead = 1'b1; memWrite = 1'b0; f3 = 3'd2; addr = 32'h20;
    busIf.busAck = 1'b0;
    expStall = 1'b1; expReq = 1'b0; expFault = 1'b0;
    step();
    busIf.busAck = 1'b0;
    expReq = 1'b1; expWe = 1'b0; expAddr = 14'h8; expBe = 4'hF;
    step();
    chkEn = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstmid_busReq", 32'(busIf.busReq), 32'd0);
    chk("rstmid_stall", 32'(stall), 32'd0);
    chk("rstmid_readData", readData, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    memRead = 1'b0; memWrite = 1'b0;
    busIf.busAck = 1'b1;
    mRd = 32'd0; expStall = 1'b0; expReq = 1'b0; expFault = 1'b0;
    chkEn = 1'b1;
    step();
    busIf.busAck = 1'b0;
    step();

`ifdef LSU_BUS_TIMEOUT_EN
    doAccess(1'b1, 1'b0, 3'd2, 32'h0040, 32'h0, 0, 32'h5555_AAAA);
    doAccess(1'b1, 1'b0, 3'd2, 32'h0044, 32'h0, 100, 32'h0);
    chk("tmo_stallCycles", 32'(stallCnt), 32'(1 + TMO));
    chk("tmo_readData", readData, 32'd0);
    doAccess(1'b1, 1'b0, 3'd2, 32'h0048, 32'h0, TMO - 1, 32'h0BAD_F00D);
    chk("tmo_edge_readData", readData, 32'h0BAD_F00D);
`endif

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      logic rd;
      logic [2:0] f;
      logic [31:0] a;
      if ($urandom_range(4) == 0) begin
        nop();
      end else begin
        rd = 1'($urandom);
        f  = 3'($urandom);
        a  = $urandom;
        if ($urandom_range(3) != 0) a = a & ~((32'd1 << f[1:0]) - 1);
        doAccess(rd, !rd, f, a, $urandom, $urandom_range(TMO + 2), $urandom);
      end
    end

    chkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage downstream of the single-cycle data path. It consumes the ALU result (effective address), the store data and funct3 of load/store instructions. It runs a req/ack transaction on the data-memory bus with byte enables, then returns a sign- or zero-extended load value on `readData`. It holds the core with `stall` until the access completes.

## Interface
- `ADDR_W`, 16: byte-address bits decoded; address bits above are ignored.
- `TIMEOUT`, 15: bus-wait limit in cycles. Used only with `LSU_BUS_TIMEOUT_EN`. Must be ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `memRead`  in  1  load request from control.
- `memWrite`  in  1  store request from control.
- `f3`  in  3  instruction funct3.
- `addr`  in  32  effective byte address (ALU result).
- `writeData`  in  32  store source register value.
- `readData`  out  32  registered, extended load result.
- `stall`  out  1  freeze PC/regfile write this cycle.
- `fault`  out  1  one-cycle pulse: misaligned, illegal or timed-out access.
- `busReq`  out  1  bus request, held until ack.
- `busWe`  out  1  1 = write.
- `busAddr`  out  ADDR_W-2  word address, `addr[ADDR_W-1:2]`.
- `busBe`  out  4  byte enables (writes; 4'b1111 on reads).
- `busWdata`  out  32  lane-replicated store data.
- `busAck`  in  1  transfer done; `busRdata` valid the same cycle.
- `busRdata`  in  32  read word.

## Operation
- **FSM states:** IDLE, BUS, DONE.
- **IDLE, no request:**
  - `stall`=0, `busReq`=0.
- **IDLE, `memRead` or `memWrite` high:**
  - `stall`=1 combinationally.
  - Legality check:
    - `f3` ∈ {000,001,010,100,101} for loads; `f3` ∈ {000,001,010} for stores.
    - Halfword needs `addr[0]`=0; word needs `addr[1:0]`=0.
    - `memRead` and `memWrite` both high is illegal.
  - Legal access:
    - Latch access type, lane, word address, `busBe` and `busWdata` into registers.
    - Next state BUS.
  - Illegal access:
    - Next state DONE, with no bus cycle.
    - `fault` pulses in DONE.
    - `readData` is loaded with 0 only for a load.
- **BUS:**
  - `busReq`=1 and `stall`=1.
  - All bus outputs come from the latched registers and are stable until ack, even if core inputs change.
  - On `busAck`: a load captures the extended lane into `readData`; next state DONE.
- **DONE:**
  - `stall`=0, so the core retires the instruction at this edge.
  - Requests are ignored this cycle.
  - Next state IDLE.
- **Store formatting:**
  - SB: `busBe`=1<<`addr[1:0]`, `busWdata`={4{wd[7:0]}}.
  - SH: `busBe`=`addr[1]`?1100:0011, `busWdata`={2{wd[15:0]}}.
  - SW: `busBe`=1111, `busWdata`=wd.
- **Load extraction:**
  - Byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `readData` holds its value until the next completed load. Stores never modify it.
- `busAck` outside BUS is ignored.

## Timing
- **Reset values (async on `rst`):**
  - State IDLE.
  - `readData`=0, `fault`=0, `busReq`=0, `busWe`=0, `busAddr`=0, `busBe`=0, `busWdata`=0.
  - `stall` is forced to 0 while `rst` is high.
- **Reset mid-BUS:**
  - `busReq` drops immediately and the transaction is abandoned.
  - A late `busAck` is ignored.
- **Latency:** minimum 3 cycles per access (IDLE, BUS with ack in its first cycle, DONE). Each wait cycle without ack adds 1.
- An illegal access takes 2 cycles (IDLE, DONE).
- `fault` is registered and high only during the DONE cycle.
- Non-memory instructions pass with `stall`=0 in IDLE and no added cycle.

## Configuration
- `LSU_BUS_TIMEOUT_EN`:
  - **Defined:** a wait counter clears on BUS entry and increments each BUS cycle without ack.
    - When it reaches `TIMEOUT`, the FSM leaves BUS and `busReq` drops.
    - Next state DONE with a `fault` pulse; a load writes `readData`=0.
    - Ack in the same cycle as expiry wins, giving a normal completion.
  - **Undefined:** no counter; BUS waits indefinitely for `busAck`.

## Test plan
- **LB sign extension:** LB, `addr`=0x0003, `busRdata`=0x80FF_1234, ack in first BUS cycle → `busAddr`=0, `readData`=0xFFFF_FF80, `stall` high 2 cycles then low in DONE.
- **SH upper half:** SH, `addr`=0x0006, `writeData`=0x0000_BEEF, ack after 3 wait cycles → `busWe`=1, `busBe`=1100, `busWdata`=0xBEEF_BEEF, `busAddr`=1, `stall` high 5 cycles, `readData` unchanged.
- **Misaligned load:** LW, `addr`=0x0002 → no `busReq`, `fault` pulses once in the 2nd cycle, `readData`=0.
- **LHU zero extension:** LHU, `addr`=0x0002, `busRdata`=0x8001_0000 → `readData`=0x0000_8001. Then an immediately following SW to 0x0008 issues `busReq` in the cycle after DONE.
- **Reset and ack during BUS:** assert `rst` during a BUS wait, then pulse `busAck` after release → `busReq` drops asynchronously, FSM stays IDLE, `readData`=0, no `fault`.
- **Timeout (`LSU_BUS_TIMEOUT_EN`, `TIMEOUT`=4):** LW with no ack → `busReq` high exactly 4 cycles, then `fault`=1 for one cycle and `readData`=0.
